// File: rtl/obstacle_gen.sv
// Scrolling obstacle generator: fixed pool of slots moving left each frame,
// LFSR-randomised spawn gaps, registered pixel hit and sticky collision flag.
module obstacle_gen #(
    parameter int NUM_SLOTS  = 4,
    parameter int OBS_W      = 16,
    parameter int OBS_H      = 32,
    parameter int GROUND_ROW = 400,
    parameter int DINO_X     = 64,
    parameter int MIN_GAP    = 40
) (
    input  logic       CLK,
    input  logic       clrn,
    input  logic       frame_tick,
    input  logic       game_status,
    input  logic [3:0] speed,
    input  logic [5:0] dinosaur_height,
    input  logic [8:0] row_addr,
    input  logic [9:0] col_addr,
    output logic       px_obstacle,
    output logic       collision
);

    localparam logic [10:0] SCREEN_W = 11'd640;
    localparam logic [9:0]  SPAWN_X  = 10'd640;
    localparam logic [10:0] W11      = 11'(OBS_W);
    localparam logic [10:0] DINO_L   = 11'(DINO_X);
    localparam logic [10:0] DINO_R   = 11'(DINO_X + 16);
    localparam logic [9:0]  ROW_TOP  = 10'(GROUND_ROW - OBS_H);
    localparam logic [9:0]  ROW_BOT  = 10'(GROUND_ROW);
    localparam logic [6:0]  H7       = 7'(OBS_H);
    localparam logic [6:0]  GAP0     = 7'(MIN_GAP);

    logic [NUM_SLOTS-1:0]       act_q, act_mv, act_nx, spawn_oh;
    logic [NUM_SLOTS-1:0][9:0]  x_q, x_mv, x_nx;
    logic [6:0]                 cnt_q, cnt_inc, cnt_nx, tgt_q, tgt_nx;
    logic [7:0]                 lfsr_q;
    logic                       status_q, rise, run_tick;
    logic                       free_found, spawn, coll_hit, px_hit;
    logic [10:0]                xe, col11;
    logic [9:0]                 row10;

    assign rise     = game_status & ~status_q;
    assign run_tick = frame_tick & game_status & ~rise;
    assign col11    = {1'b0, col_addr};
    assign row10    = {1'b0, row_addr};

    always_comb begin
        act_mv     = act_q;
        x_mv       = x_q;
        spawn_oh   = '0;
        free_found = 1'b0;
        coll_hit   = 1'b0;
        px_hit     = 1'b0;
        xe         = '0;

        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (act_q[i]) begin
                if (x_q[i] < {6'd0, speed}) act_mv[i] = 1'b0;
                else                        x_mv[i]   = x_q[i] - {6'd0, speed};
            end
        end

        // Counter saturates at the target so a blocked spawn retries every tick.
        cnt_inc = (cnt_q >= tgt_q) ? cnt_q : cnt_q + 7'd1;

        // Free-slot search runs on post-motion state so a slot retired this
        // tick can be reused by the spawn of the same tick.
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!act_mv[i] && !free_found) begin
                spawn_oh[i] = 1'b1;
                free_found  = 1'b1;
            end
        end
        spawn = (cnt_inc >= tgt_q) && free_found;

        act_nx = act_mv;
        x_nx   = x_mv;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (spawn && spawn_oh[i]) begin
                act_nx[i] = 1'b1;
                x_nx[i]   = SPAWN_X;
            end
        end
        cnt_nx = spawn ? '0 : cnt_inc;
        tgt_nx = spawn ? GAP0 + {1'b0, lfsr_q[5:0]} : tgt_q;

        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            xe = {1'b0, x_mv[i]};
            if (act_mv[i] && xe < DINO_R && DINO_L < xe + W11) coll_hit = 1'b1;
        end
        if ({1'b0, dinosaur_height} >= H7) coll_hit = 1'b0;

        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            xe = {1'b0, x_q[i]};
            if (act_q[i] && col11 >= xe && col11 < xe + W11) px_hit = 1'b1;
        end
        if (col11 >= SCREEN_W || row10 < ROW_TOP || row10 >= ROW_BOT) px_hit = 1'b0;
    end

    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            act_q       <= '0;
            x_q         <= '0;
            cnt_q       <= '0;
            tgt_q       <= GAP0;
            lfsr_q      <= 8'hA5;
            status_q    <= 1'b0;
            px_obstacle <= 1'b0;
            collision   <= 1'b0;
        end else begin
            lfsr_q      <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            status_q    <= game_status;
            px_obstacle <= px_hit;
            if (rise) begin
                act_q     <= '0;
                x_q       <= '0;
                cnt_q     <= '0;
                tgt_q     <= GAP0;
                collision <= 1'b0;
            end else if (run_tick) begin
                act_q <= act_nx;
                x_q   <= x_nx;
                cnt_q <= cnt_nx;
                tgt_q <= tgt_nx;
                if (coll_hit) collision <= 1'b1;
            end
        end
    end

endmodule
